// File: rtl/pb_uart_regs_pkg.sv
// rtl/pb_uart_regs_pkg.sv - register offsets, INT bit positions and helpers for pb_uart_regs
package pb_uart_regs_pkg;

    // Register offsets within the 8-port block (port_id[2:0])
    localparam logic [2:0] PB_UART_TX_DATA      = 3'd0;
    localparam logic [2:0] PB_UART_RX_DATA      = 3'd1;
    localparam logic [2:0] PB_UART_FIFO_STATUS  = 3'd2;
    localparam logic [2:0] PB_UART_TX_CONTROL   = 3'd3;
    localparam logic [2:0] PB_UART_BAUD_CONTROL = 3'd4;
    localparam logic [2:0] PB_UART_BAUD_COUNT   = 3'd5;
    localparam logic [2:0] PB_UART_BAUD_STATUS  = 3'd6;
    localparam logic [2:0] PB_UART_INT          = 3'd7;

    // INT register bit positions
    localparam int PB_UART_INT_TX_PEND = 0;
    localparam int PB_UART_INT_RX_PEND = 1;
    localparam int PB_UART_INT_TX_EN   = 4;
    localparam int PB_UART_INT_RX_EN   = 5;

    // TX_CONTROL bit that resets the UART TX FIFO; it only ever lives for one cycle
    localparam int PB_UART_TX_FIFO_RST = 1;

    // Interrupt block state as seen through the INT register
    typedef struct packed {
        logic rx_en;
        logic tx_en;
        logic rx_pend;
        logic tx_pend;
    } pb_uart_int_state_t;

    // Block hit test: only the upper five port_id bits select the block
    function automatic logic pb_uart_hit(input logic [7:0] port_id, input logic [7:0] base);
        return port_id[7:3] == base[7:3];
    endfunction

    // Assemble the INT read value; unused bits read as 0
    function automatic logic [7:0] pb_uart_int_pack(input pb_uart_int_state_t s);
        logic [7:0] v;
        v = 8'h00;
        v[PB_UART_INT_TX_PEND] = s.tx_pend;
        v[PB_UART_INT_RX_PEND] = s.rx_pend;
        v[PB_UART_INT_TX_EN]   = s.tx_en;
        v[PB_UART_INT_RX_EN]   = s.rx_en;
        return v;
    endfunction

endpackage

// File: rtl/pb_uart_regs_int_ctrl.sv
// rtl/pb_uart_regs_int_ctrl.sv - UART interrupt edge detect, pending/enable bits and request/ack
module pb_uart_int_ctrl
    import pb_uart_regs_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic tx_int_i,
    input  logic rx_int_i,
    input  logic int_wr_i,
    input  logic tx_clr_i,
    input  logic rx_clr_i,
    input  logic tx_en_wr_i,
    input  logic rx_en_wr_i,
    input  logic ack_i,
    output logic tx_pend_o,
    output logic rx_pend_o,
    output logic tx_en_o,
    output logic rx_en_o,
    output logic irq_o
);

    logic tx_int_q, rx_int_q;
    logic tx_pend_q, tx_pend_d;
    logic rx_pend_q, rx_pend_d;
    logic tx_en_q, tx_en_d;
    logic rx_en_q, rx_en_d;
    logic active_q, active_d;
    logic irq_q, irq_d;
    logic tx_rise, rx_rise;

    // Next state: edges set pending (beating a same-cycle W1C), enables load on INT writes,
    // the request fires on a fresh 0->1 of active and holds until acked (a new set beats ack)
    always_comb begin
        tx_rise   = tx_int_i & ~tx_int_q;
        rx_rise   = rx_int_i & ~rx_int_q;
        tx_pend_d = tx_rise | (tx_pend_q & ~(int_wr_i & tx_clr_i));
        rx_pend_d = rx_rise | (rx_pend_q & ~(int_wr_i & rx_clr_i));
        tx_en_d   = int_wr_i ? tx_en_wr_i : tx_en_q;
        rx_en_d   = int_wr_i ? rx_en_wr_i : rx_en_q;
        active_d  = (tx_pend_q & tx_en_q) | (rx_pend_q & rx_en_q);
        irq_d     = (active_d & ~active_q) | (irq_q & ~ack_i);
    end

    // State registers; previous-int samples clear to 0 so an int high out of reset still counts as an edge
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_int_q  <= 1'b0;
            rx_int_q  <= 1'b0;
            tx_pend_q <= 1'b0;
            rx_pend_q <= 1'b0;
            tx_en_q   <= 1'b0;
            rx_en_q   <= 1'b0;
            active_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            tx_int_q  <= tx_int_i;
            rx_int_q  <= rx_int_i;
            tx_pend_q <= tx_pend_d;
            rx_pend_q <= rx_pend_d;
            tx_en_q   <= tx_en_d;
            rx_en_q   <= rx_en_d;
            active_q  <= active_d;
            irq_q     <= irq_d;
        end
    end

    assign tx_pend_o = tx_pend_q;
    assign rx_pend_o = rx_pend_q;
    assign tx_en_o   = tx_en_q;
    assign rx_en_o   = rx_en_q;
    assign irq_o     = irq_q;

endmodule

// File: rtl/pb_uart_regs.sv
// rtl/pb_uart_regs.sv - PicoBlaze port decode, UART register file and registered read mux
module pb_uart_regs
    import pb_uart_regs_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'h00
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] port_id,
    input  logic       write_strobe,
    input  logic       read_strobe,
    input  logic [7:0] out_port,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic       interrupt_ack,
    output logic [7:0] uart_tx_data,
    output logic       uart_tx_write,
    output logic [7:0] uart_tx_control,
    input  logic [7:0] uart_rx_data,
    output logic       uart_rx_read,
    input  logic [7:0] uart_fifo_status,
    output logic [7:0] uart_baud_control,
    output logic [7:0] uart_baud_count,
    input  logic [7:0] uart_baud_status,
    input  logic       uart_tx_int,
    input  logic       uart_rx_int
);

    logic       hit;
    logic [2:0] offset;
    logic       wr_en, rd_en;
    logic       wr_tx_data, wr_tx_ctrl, wr_baud_ctrl, wr_baud_cnt, wr_int;
    logic       rd_rx_data;

    logic [7:0] tx_data_q;
    logic       tx_write_q;
    logic [7:0] tx_control_q;
    logic       rx_read_q;
    logic [7:0] baud_control_q;
    logic [7:0] baud_count_q;
    logic [7:0] in_port_q, in_port_d;

    pb_uart_int_state_t int_state;
    logic               irq;

    // Port decode: one strobe qualified by block hit, then split per offset
    always_comb begin
        hit          = pb_uart_hit(port_id, BASE_ADDR);
        offset       = port_id[2:0];
        wr_en        = write_strobe & hit;
        rd_en        = read_strobe & hit;
        wr_tx_data   = wr_en && (offset == PB_UART_TX_DATA);
        wr_tx_ctrl   = wr_en && (offset == PB_UART_TX_CONTROL);
        wr_baud_ctrl = wr_en && (offset == PB_UART_BAUD_CONTROL);
        wr_baud_cnt  = wr_en && (offset == PB_UART_BAUD_COUNT);
        wr_int       = wr_en && (offset == PB_UART_INT);
        rd_rx_data   = rd_en && (offset == PB_UART_RX_DATA);
    end

    // Read mux on the raw offset; registered below so data lines up with read_strobe
    always_comb begin
        in_port_d = 8'h00;
        case (offset)
            PB_UART_TX_DATA:      in_port_d = 8'h00;
            PB_UART_RX_DATA:      in_port_d = uart_rx_data;
            PB_UART_FIFO_STATUS:  in_port_d = uart_fifo_status;
            PB_UART_TX_CONTROL:   in_port_d = tx_control_q;
            PB_UART_BAUD_CONTROL: in_port_d = baud_control_q;
            PB_UART_BAUD_COUNT:   in_port_d = baud_count_q;
            PB_UART_BAUD_STATUS:  in_port_d = uart_baud_status;
            PB_UART_INT:          in_port_d = pb_uart_int_pack(int_state);
            default:              in_port_d = 8'h00;
        endcase
    end

    // Register file and one-cycle strobes; the FIFO reset bit drops back the cycle after it was written
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_data_q      <= 8'h00;
            tx_write_q     <= 1'b0;
            tx_control_q   <= 8'h00;
            rx_read_q      <= 1'b0;
            baud_control_q <= 8'h00;
            baud_count_q   <= 8'h00;
            in_port_q      <= 8'h00;
        end else begin
            tx_write_q <= wr_tx_data;
            rx_read_q  <= rd_rx_data;
            in_port_q  <= in_port_d;
            if (wr_tx_data) begin
                tx_data_q <= out_port;
            end
            if (wr_tx_ctrl) begin
                tx_control_q <= out_port;
            end else begin
                tx_control_q[PB_UART_TX_FIFO_RST] <= 1'b0;
            end
            if (wr_baud_ctrl) begin
                baud_control_q <= out_port;
            end
            if (wr_baud_cnt) begin
                baud_count_q <= out_port;
            end
        end
    end

    pb_uart_int_ctrl u_int_ctrl (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .tx_int_i   (uart_tx_int),
        .rx_int_i   (uart_rx_int),
        .int_wr_i   (wr_int),
        .tx_clr_i   (out_port[PB_UART_INT_TX_PEND]),
        .rx_clr_i   (out_port[PB_UART_INT_RX_PEND]),
        .tx_en_wr_i (out_port[PB_UART_INT_TX_EN]),
        .rx_en_wr_i (out_port[PB_UART_INT_RX_EN]),
        .ack_i      (interrupt_ack),
        .tx_pend_o  (int_state.tx_pend),
        .rx_pend_o  (int_state.rx_pend),
        .tx_en_o    (int_state.tx_en),
        .rx_en_o    (int_state.rx_en),
        .irq_o      (irq)
    );

    assign in_port           = in_port_q;
    assign interrupt         = irq;
    assign uart_tx_data      = tx_data_q;
    assign uart_tx_write     = tx_write_q;
    assign uart_tx_control   = tx_control_q;
    assign uart_rx_read      = rx_read_q;
    assign uart_baud_control = baud_control_q;
    assign uart_baud_count   = baud_count_q;

endmodule

// File: tb/tb_pb_uart_regs.sv
// tb/tb_pb_uart_regs.sv - self-checking bench for pb_uart_regs with a behavioural model
module tb_pb_uart_regs;

    localparam logic [7:0] BASE = 8'h40;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic [7:0] port_id = 8'h00;
    logic       write_strobe = 1'b0;
    logic       read_strobe = 1'b0;
    logic [7:0] out_port = 8'h00;
    logic [7:0] in_port;
    logic       interrupt;
    logic       interrupt_ack = 1'b0;
    logic [7:0] uart_tx_data;
    logic       uart_tx_write;
    logic [7:0] uart_tx_control;
    logic [7:0] uart_rx_data = 8'h00;
    logic       uart_rx_read;
    logic [7:0] uart_fifo_status = 8'h00;
    logic [7:0] uart_baud_control;
    logic [7:0] uart_baud_count;
    logic [7:0] uart_baud_status = 8'h00;
    logic       uart_tx_int = 1'b0;
    logic       uart_rx_int = 1'b0;

    always #5 clk_i = ~clk_i;

    pb_uart_regs #(.BASE_ADDR(BASE)) dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .port_id           (port_id),
        .write_strobe      (write_strobe),
        .read_strobe       (read_strobe),
        .out_port          (out_port),
        .in_port           (in_port),
        .interrupt         (interrupt),
        .interrupt_ack     (interrupt_ack),
        .uart_tx_data      (uart_tx_data),
        .uart_tx_write     (uart_tx_write),
        .uart_tx_control   (uart_tx_control),
        .uart_rx_data      (uart_rx_data),
        .uart_rx_read      (uart_rx_read),
        .uart_fifo_status  (uart_fifo_status),
        .uart_baud_control (uart_baud_control),
        .uart_baud_count   (uart_baud_count),
        .uart_baud_status  (uart_baud_status),
        .uart_tx_int       (uart_tx_int),
        .uart_rx_int       (uart_rx_int)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_regs [8];          // software-visible register contents by offset (3,4,5 used)
    logic [7:0] m_tx_data = 8'h00;
    logic       m_tx_write = 1'b0;
    logic       m_rx_read = 1'b0;
    logic [7:0] m_in_port = 8'h00;
    logic       m_tx_pend = 1'b0, m_rx_pend = 1'b0, m_tx_en = 1'b0, m_rx_en = 1'b0;
    logic       m_irq = 1'b0;
    logic       m_last_tx = 1'b0, m_last_rx = 1'b0, m_last_active = 1'b0;

    function automatic logic [7:0] model_read(input logic [2:0] off);
        case (off)
            3'd1: return uart_rx_data;
            3'd2: return uart_fifo_status;
            3'd3, 3'd4, 3'd5: return m_regs[off];
            3'd6: return uart_baud_status;
            3'd7: return {2'b00, m_rx_en, m_tx_en, 2'b00, m_rx_pend, m_tx_pend};
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
            m_tx_data = 0; m_tx_write = 0; m_rx_read = 0; m_in_port = 0;
            m_tx_pend = 0; m_rx_pend = 0; m_tx_en = 0; m_rx_en = 0;
            m_irq = 0; m_last_tx = 0; m_last_rx = 0; m_last_active = 0;
        end else begin
            logic       is_hit, is_wr, is_rd, active, tx_edge, rx_edge;
            logic [2:0] off;
            is_hit = (port_id[7:3] == BASE[7:3]);
            off    = port_id[2:0];
            is_wr  = write_strobe && is_hit;
            is_rd  = read_strobe && is_hit;
            // everything below reads the state as it was before this edge
            m_in_port = model_read(off);
            active = (m_tx_pend && m_tx_en) || (m_rx_pend && m_rx_en);
            if (active && !m_last_active) m_irq = 1'b1;
            else if (interrupt_ack) m_irq = 1'b0;
            m_last_active = active;
            tx_edge = uart_tx_int && !m_last_tx;
            rx_edge = uart_rx_int && !m_last_rx;
            m_last_tx = uart_tx_int;
            m_last_rx = uart_rx_int;
            if (is_wr && off == 3'd7 && out_port[0]) m_tx_pend = 1'b0;
            if (is_wr && off == 3'd7 && out_port[1]) m_rx_pend = 1'b0;
            if (tx_edge) m_tx_pend = 1'b1;
            if (rx_edge) m_rx_pend = 1'b1;
            if (is_wr && off == 3'd7) begin
                m_tx_en = out_port[4];
                m_rx_en = out_port[5];
            end
            m_regs[3][1] = 1'b0;
            if (is_wr && (off == 3'd3 || off == 3'd4 || off == 3'd5)) m_regs[off] = out_port;
            m_tx_write = is_wr && off == 3'd0;
            if (m_tx_write) m_tx_data = out_port;
            m_rx_read = is_rd && off == 3'd1;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [63:0] dut_vec, mdl_vec;
    assign dut_vec = {21'd0, in_port, interrupt, uart_tx_data, uart_tx_write, uart_tx_control,
                      uart_rx_read, uart_baud_control, uart_baud_count};
    assign mdl_vec = {21'd0, m_in_port, m_irq, m_tx_data, m_tx_write, m_regs[3],
                      m_rx_read, m_regs[4], m_regs[5]};

    always @(negedge clk_i) check("cycle_outputs", dut_vec, mdl_vec);

    // ---------------- stimulus ----------------
    task automatic pb_write(input logic [7:0] port, input logic [7:0] data);
        port_id = port; out_port = data; write_strobe = 1'b1;
        @(negedge clk_i);
        write_strobe = 1'b0;
    endtask

    task automatic pb_read(input logic [7:0] port, output logic [7:0] data);
        port_id = port;
        @(negedge clk_i);
        read_strobe = 1'b1;
        data = in_port;
        @(negedge clk_i);
        read_strobe = 1'b0;
    endtask

    logic [7:0] rd;

    initial begin
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        check("reset_outputs", dut_vec, 64'd0);

        // reset in the middle of a write clears outputs without a clock
        pb_write(BASE | 8'd5, 8'h77);
        pb_write(BASE | 8'd4, 8'h11);
        check("baud_count_loaded", 64'(uart_baud_count), 64'h77);
        port_id = BASE | 8'd3; out_port = 8'hFF; write_strobe = 1'b1;
        #2 rst_n_i = 1'b0;
        #1 check("async_reset_outputs", dut_vec, 64'd0);
        @(negedge clk_i); write_strobe = 1'b0;
        @(negedge clk_i); rst_n_i = 1'b1;
        pb_read(BASE | 8'd3, rd); check("rd_tx_ctrl_after_reset", 64'(rd), 64'h00);
        pb_read(BASE | 8'd4, rd); check("rd_baud_ctrl_after_reset", 64'(rd), 64'h00);
        pb_read(BASE | 8'd5, rd); check("rd_baud_cnt_after_reset", 64'(rd), 64'h00);

        // TX data write pulse and base mismatch
        pb_write(BASE | 8'd0, 8'hA5);
        check("tx_write_pulse", 64'(uart_tx_write), 64'd1);
        check("tx_data_a5", 64'(uart_tx_data), 64'hA5);
        @(negedge clk_i);
        check("tx_write_single", 64'(uart_tx_write), 64'd0);
        pb_write(BASE ^ 8'h08, 8'h5A);
        check("tx_write_miss", 64'(uart_tx_write), 64'd0);
        check("tx_data_miss", 64'(uart_tx_data), 64'hA5);

        // RX read data and pop pulse
        uart_rx_data = 8'h3C;
        pb_read(BASE | 8'd1, rd);
        check("rx_data_read", 64'(rd), 64'h3C);
        check("rx_read_pulse", 64'(uart_rx_read), 64'd1);
        @(negedge clk_i);
        check("rx_read_single", 64'(uart_rx_read), 64'd0);

        // TX FIFO reset bit self-clears
        pb_write(BASE | 8'd3, 8'h02);
        check("fifo_rst_high", 64'(uart_tx_control), 64'h02);
        @(negedge clk_i);
        check("fifo_rst_cleared", 64'(uart_tx_control), 64'h00);
        pb_read(BASE | 8'd3, rd);
        check("rd_tx_ctrl_cleared", 64'(rd), 64'h00);

        // RX interrupt: enable, pend, ack, clear, re-arm
        pb_write(BASE | 8'd7, 8'h20);
        uart_rx_int = 1'b1;
        repeat (2) @(negedge clk_i);
        check("rx_irq_set", 64'(interrupt), 64'd1);
        pb_read(BASE | 8'd7, rd);
        check("rd_int_rx_pend", 64'(rd), 64'h22);
        interrupt_ack = 1'b1;
        @(negedge clk_i);
        interrupt_ack = 1'b0;
        check("irq_acked", 64'(interrupt), 64'd0);
        pb_write(BASE | 8'd7, 8'h22);
        pb_read(BASE | 8'd7, rd);
        check("rd_int_rx_cleared", 64'(rd), 64'h20);
        check("irq_stays_low", 64'(interrupt), 64'd0);
        uart_rx_int = 1'b0;
        @(negedge clk_i);
        uart_rx_int = 1'b1;
        repeat (2) @(negedge clk_i);
        check("rx_irq_rearmed", 64'(interrupt), 64'd1);
        uart_rx_int = 1'b0;
        interrupt_ack = 1'b1;
        @(negedge clk_i);
        interrupt_ack = 1'b0;

        // set beats W1C in the same cycle
        pb_write(BASE | 8'd7, 8'h03);
        uart_tx_int = 1'b1;
        pb_write(BASE | 8'd7, 8'h01);
        uart_tx_int = 1'b0;
        pb_read(BASE | 8'd7, rd);
        check("tx_set_beats_clear", 64'(rd), 64'h01);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            port_id          = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {BASE[7:3], 3'($urandom)};
            out_port         = 8'($urandom);
            write_strobe     = ($urandom_range(0, 2) == 0);
            read_strobe      = !write_strobe && ($urandom_range(0, 2) == 0);
            uart_rx_data     = 8'($urandom);
            uart_fifo_status = 8'($urandom);
            uart_baud_status = 8'($urandom);
            if ($urandom_range(0, 7) == 0) uart_tx_int = ~uart_tx_int;
            if ($urandom_range(0, 7) == 0) uart_rx_int = ~uart_rx_int;
            interrupt_ack    = ($urandom_range(0, 9) == 0);
            @(negedge clk_i);
        end
        write_strobe = 1'b0; read_strobe = 1'b0; interrupt_ack = 1'b0;
        @(negedge clk_i);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
